cordic_arbiter: RTL
===================

Name: cordic_arbiter

Overview:
- Shares one cordic_engine between two independent requesters (port 0, port 1).
- Round-robin grant; honours the engine's pop back-pressure through a one-entry staging register.
- Tracks outstanding operations in a requester-tag FIFO and steers each engine result back to the requester that issued it.
- Sits directly in front of cordic_engine; requesters see a simple valid/ready issue port and a valid-only response port.

Parameters:
- IO_BW, 32, width of phase and result buses; matches cordic_engine IO_BW.
- DEPTH, 8, maximum outstanding (issued, not yet returned) operations; tag FIFO depth, power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- r0_valid  input  1  requester 0 has an operation.
- r0_phase  input  IO_BW  requester 0 phase.
- r0_mode  input  3  requester 0 mode.
- r0_ready  output  1  requester 0 operation granted this cycle (combinational).
- r1_valid, r1_phase, r1_mode, r1_ready: same as port 0, for requester 1.
- e_phase  output  IO_BW  to engine phase.
- e_mode  output  3  to engine mode.
- e_valid_in  output  1  to engine valid_in.
- e_pop  input  1  from engine pop; 1 = engine cannot accept this cycle.
- e_valid_out  input  1  from engine valid_out; one-cycle pulse per result, in issue order.
- e_result  input  IO_BW  from engine result.
- o_result  output  IO_BW  registered result to requesters.
- o0_valid  output  1  o_result belongs to requester 0.
- o1_valid  output  1  o_result belongs to requester 1.
- err_orphan  output  1  sticky: result arrived with no outstanding tag.

Behaviour:
- Reset (async, rst_n=0): every output register 0 (e_valid_in, e_phase, e_mode, o_result, o0_valid, o1_valid, err_orphan); tag FIFO empty; outstanding count 0; rr pointer = 0, so port 0 has priority on the first contention.
- Staging register (e_valid_in/e_phase/e_mode):
  - Engine accepts at an edge where e_valid_in=1 and e_pop=0.
  - While e_valid_in=1 and e_pop=1, the register holds its value unchanged.
- Grant condition: staging empty, or accepted this cycle; AND outstanding + staged < DEPTH, where staged counts only an entry not being accepted this cycle. A result retiring in the same cycle does not free a credit.
- Arbitration:
  - Only one valid: that port is granted.
  - Both valid: grant the port other than the last granted one.
  - rr pointer updates only on a grant.
  - rX_ready = grant for port X; the request is consumed at the edge where rX_valid & rX_ready.
- Issue latency: granted at edge t -> e_valid_in=1 with that phase/mode from t+1. Back-to-back grants give back-to-back e_valid_in when e_pop stays 0.
- Tag FIFO:
  - Push the requester id on engine acceptance; pop on e_valid_out.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Response:
  - e_valid_out at edge t -> o_result = e_result and exactly one of o0_valid/o1_valid = 1 (per FIFO head) during cycle t+1; both 0 otherwise.
  - Response latency is 1 cycle.
- Orphan: e_valid_out with FIFO empty -> no o*_valid; err_orphan set and held until reset.
- Full: outstanding + staged = DEPTH -> r0_ready = r1_ready = 0 until a result retires.
- Reset mid-operation: all in-flight tags discarded; the engine must be reset by the same rst_n.

Optional Feature:
- Macro CORDIC_ARB_STAT_EN.
- Defined: adds outputs stat_issue0 and stat_issue1 (16-bit each) counting engine acceptances per requester, saturating at 16'hFFFF; cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single requester: r0 only, 4 ops, e_pop=0, engine returns results 10 cycles later -> e_valid_in on 4 consecutive cycles starting 1 cycle after the first grant; 4 o0_valid pulses with matching results; o1_valid never 1.
- Contention: r0 and r1 both valid continuously, 6 ops each -> grants alternate 0,1,0,1,..., port 0 first after reset; results routed to the correct port in issue order.
- Back-pressure: e_pop=1 for 5 cycles while e_valid_in=1 -> e_phase/e_mode stable, no further grants, exactly one acceptance after e_pop falls.
- Credit limit with DEPTH=8: engine withholds results -> exactly 8 acceptances, then r0_ready = r1_ready = 0; one e_valid_out -> one new grant, and not in the same cycle as the retire.
- Orphan: e_valid_out pulsed with no issues after reset -> err_orphan=1 from the next cycle, o0_valid = o1_valid = 0; stays 1 until rst_n=0.
- Mid-operation reset: rst_n pulsed low with 3 outstanding -> all outputs 0 immediately (asynchronous); after release, the first grant goes to port 0 and there are no spurious o*_valid.

Source files
------------

// File: rtl/cordic_arbiter.sv
// Two-port round-robin front end for a shared cordic_engine: staging register,
// credit-limited issue, and a requester-tag FIFO that steers results back.
// Optional per-port issue counters are enabled with `define CORDIC_ARB_STAT_EN.
module cordic_arbiter #(
  parameter int IO_BW = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  input  logic [IO_BW-1:0] r0_phase,
  input  logic [2:0]       r0_mode,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic [IO_BW-1:0] r1_phase,
  input  logic [2:0]       r1_mode,
  output logic             r1_ready,
  output logic [IO_BW-1:0] e_phase,
  output logic [2:0]       e_mode,
  output logic             e_valid_in,
  input  logic             e_pop,
  input  logic             e_valid_out,
  input  logic [IO_BW-1:0] e_result,
  output logic [IO_BW-1:0] o_result,
  output logic             o0_valid,
  output logic             o1_valid,
`ifdef CORDIC_ARB_STAT_EN
  output logic [15:0]      stat_issue0,
  output logic [15:0]      stat_issue1,
`endif
  output logic             err_orphan
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          accept;
  logic          stg_hold;
  logic          stg_port;
  logic          credit_ok;
  logic          can_grant;
  logic          grant0;
  logic          grant1;
  logic          prio;
  logic [CW-1:0] cnt;
  logic [CW:0]   inflight;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          tag_mem [DEPTH];
  logic          fifo_empty;
  logic          do_push;
  logic          do_pop;
  logic          head_tag;

  assign accept   = e_valid_in & ~e_pop;
  assign stg_hold = e_valid_in & e_pop;

  // The entry leaving the staging register this cycle already counts as
  // outstanding, and a same-cycle retire is not credited until the next cycle.
  assign inflight  = {1'b0, cnt} + {{CW{1'b0}}, e_valid_in};
  assign credit_ok = inflight < (CW+1)'(DEPTH);
  assign can_grant = ~stg_hold & credit_ok;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_grant) begin
      if (r0_valid && r1_valid) begin
        grant0 = ~prio;
        grant1 = prio;
      end else begin
        grant0 = r0_valid;
        grant1 = r1_valid;
      end
    end
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // prio names the port that wins the next contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_in <= 1'b0;
      e_phase    <= '0;
      e_mode     <= '0;
      stg_port   <= 1'b0;
      prio       <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        e_valid_in <= 1'b1;
        e_phase    <= grant1 ? r1_phase : r0_phase;
        e_mode     <= grant1 ? r1_mode : r0_mode;
        stg_port   <= grant1;
        prio       <= grant0;
      end else if (accept) begin
        e_valid_in <= 1'b0;
      end
    end
  end

  assign fifo_empty = (cnt == '0);
  assign do_push    = accept;
  assign do_pop     = e_valid_out & ~fifo_empty;
  assign head_tag   = tag_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (!do_push && do_pop) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) tag_mem[wr_ptr] <= stg_port;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_result   <= '0;
      o0_valid   <= 1'b0;
      o1_valid   <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      o0_valid <= do_pop & ~head_tag;
      o1_valid <= do_pop & head_tag;
      if (e_valid_out) o_result <= e_result;
      if (e_valid_out && fifo_empty) err_orphan <= 1'b1;
    end
  end

`ifdef CORDIC_ARB_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue0 <= '0;
      stat_issue1 <= '0;
    end else if (accept) begin
      if (!stg_port && stat_issue0 != 16'hFFFF) stat_issue0 <= stat_issue0 + 16'd1;
      if (stg_port && stat_issue1 != 16'hFFFF)  stat_issue1 <= stat_issue1 + 16'd1;
    end
  end
`endif

endmodule
